full_adder_gl: RTL and testbench

Gate-level full adder with a registered output stage. The core is a ripple chain of one-bit full-adder cells built only from AND/OR/XOR gate primitives. It adds operands a and b and carry-in cin. Results are captured on the rising clock edge, with a valid flag. It is used as a leaf arithmetic cell in datapaths and as the golden gate-level reference for adder verification.

---
 rtl/full_adder_gl.sv | 68 ++++++
 tb/tb_full_adder_gl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/full_adder_gl.sv
// rtl/full_adder_gl.sv - gate-level ripple-carry adder with registered sum/carry and valid flag
// Each bit is a primitive AND/OR/XOR full-adder cell; only the output stage is registered.

module full_adder_gl #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             out_valid
);

   logic [WIDTH-1:0] w_sum;
   logic             w_cout;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_valid;

   // Each cell owns its carry nets so the chain is a set of distinct signals, not one self-referencing vector.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic w_ci;
      logic w_p;
      logic w_g;
      logic w_t;
      logic w_co;
      logic w_s;

      if (i == 0) begin : g_first
         assign w_ci = cin;
      end else begin : g_rest
         assign w_ci = g_bit[i-1].w_co;
      end

      xor u_p  (w_p,  a[i], b[i]);
      xor u_s  (w_s,  w_p,  w_ci);
      and u_g  (w_g,  a[i], b[i]);
      and u_t  (w_t,  w_ci, w_p);
      or  u_co (w_co, w_g,  w_t);

      assign w_sum[i] = w_s;
   end

   assign w_cout = g_bit[WIDTH-1].w_co;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_sum   <= w_sum;
            r_carry <= w_cout;
         end
      end
   end

   assign sum       = r_sum;
   assign carry     = r_carry;
   assign out_valid = r_valid;

endmodule

// File: tb/tb_full_adder_gl.sv
// tb/tb_full_adder_gl.sv - self-checking bench for full_adder_gl at WIDTH=1 and WIDTH=4
// Both instances run side by side against an arithmetic reference with hold/reset rules.

module tb_full_adder_gl;

   logic       clk = 1'b0;
   logic       rst;
   logic       v1, v4;
   logic       a1, b1, c1;
   logic [3:0] a4, b4;
   logic       c4;
   logic       s1, co1, ov1;
   logic [3:0] s4;
   logic       co4, ov4;

   int n_assert = 0;
   int n_fail   = 0;

   logic       m_s1, m_co1, m_ov1;
   logic [3:0] m_s4;
   logic       m_co4, m_ov4;

   always #5 clk = ~clk;

   full_adder_gl #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
      .sum(s1), .carry(co1), .out_valid(ov1)
   );

   full_adder_gl #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .cin(c4),
      .sum(s4), .carry(co4), .out_valid(ov4)
   );

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: {carry,sum} = a+b+cin when valid, hold otherwise, zero on reset.
   task automatic step(input logic r,
                       input logic iv1, input logic ia1, input logic ib1, input logic ic1,
                       input logic iv4, input logic [3:0] ia4, input logic [3:0] ib4, input logic ic4,
                       input string tag);
      int t;
      @(negedge clk);
      rst = r;
      v1 = iv1; a1 = ia1; b1 = ib1; c1 = ic1;
      v4 = iv4; a4 = ia4; b4 = ib4; c4 = ic4;
      if (r) begin
         m_s1 = 1'b0; m_co1 = 1'b0; m_ov1 = 1'b0;
         m_s4 = 4'h0; m_co4 = 1'b0; m_ov4 = 1'b0;
      end else begin
         m_ov1 = iv1;
         if (iv1) begin
            t = int'(ia1) + int'(ib1) + int'(ic1);
            m_s1  = t[0];
            m_co1 = t[1];
         end
         m_ov4 = iv4;
         if (iv4) begin
            t = int'(ia4) + int'(ib4) + int'(ic4);
            m_s4  = t[3:0];
            m_co4 = t[4];
         end
      end
      @(posedge clk);
      #1;
      chk({tag, ".w1.sum"},   {3'b0, s1},  {3'b0, m_s1});
      chk({tag, ".w1.carry"}, {3'b0, co1}, {3'b0, m_co1});
      chk({tag, ".w1.valid"}, {3'b0, ov1}, {3'b0, m_ov1});
      chk({tag, ".w4.sum"},   s4,          m_s4);
      chk({tag, ".w4.carry"}, {3'b0, co4}, {3'b0, m_co4});
      chk({tag, ".w4.valid"}, {3'b0, ov4}, {3'b0, m_ov4});
   endtask

   initial begin
      rst = 1'b1; v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
      v4 = 1'b0; a4 = 4'h0; b4 = 4'h0; c4 = 1'b0;

      step(1, 0,0,0,0, 0,4'h0,4'h0,0, "reset0");
      step(1, 1,1,1,1, 1,4'hF,4'hF,1, "reset_prio");

      step(0, 1,0,0,0, 1,4'h0,4'h0,0, "zero");
      chk("zero_const.w1.sum", {3'b0, s1}, 4'h0);
      chk("zero_const.w1.valid", {3'b0, ov1}, 4'h1);

      step(0, 1,1,0,0, 1,4'hF,4'h0,1, "seq_a");
      chk("wrap.w4.sum", s4, 4'h0);
      chk("wrap.w4.carry", {3'b0, co4}, 4'h1);
      step(0, 1,0,1,0, 1,4'hF,4'hF,1, "seq_b");
      chk("allones.w4.sum", s4, 4'hF);
      chk("allones.w4.carry", {3'b0, co4}, 4'h1);
      step(0, 1,1,1,1, 1,4'h0,4'h0,0, "seq_c");
      chk("seq_c.w1.sum", {3'b0, s1}, 4'h1);
      chk("seq_c.w1.carry", {3'b0, co1}, 4'h1);

      // Hold for three idle cycles, then reset wins over a concurrent valid input.
      for (int k = 0; k < 3; k++)
         step(0, 0,0,0,0, 0,4'h5,4'hA,1, "hold");
      chk("hold_const.w1.sum", {3'b0, s1}, 4'h1);
      chk("hold_const.w1.carry", {3'b0, co1}, 4'h1);
      step(1, 1,1,1,0, 1,4'h7,4'h3,0, "rst_mid");

      for (int k = 0; k < 8; k++)
         step(0, 1, k[2], k[1], k[0], 1, 4'(k), 4'(15 - k), k[0], "sweep");

      for (int k = 0; k < 200; k++)
         step(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), "rand");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
